// File: rtl/user_event_pkg.sv
// Shared definitions for the multi-channel user event generator:
// FSM states, payload mode encodings, header magic and LFSR constants.
package user_event_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_FREE = 3'd1,
      ST_HDR0      = 3'd2,
      ST_HDR1      = 3'd3,
      ST_PAYLOAD   = 3'd4,
      ST_COMMIT    = 3'd5,
      ST_GAP       = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      MODE_INCR  = 2'd0,
      MODE_FIXED = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_ZERO  = 2'd3
   } mode_e;

   localparam logic [7:0]  HDR_MAGIC    = 8'hEB;
   localparam logic [15:0] FIXED_PREFIX = 16'hA5A5;

   // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting towards the MSB:
   // feedback taps sit at bit positions 31, 21, 1 and 0.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/user_event_gen_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after the
// pointer (wrapping modulo NUM_CH); the pointer moves past the granted
// channel whenever the grant is accepted.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              accept_i,
   output logic [NUM_CH-1:0] grant_oh_o,
   output logic [IDX_W-1:0]  grant_idx_o,
   output logic              valid_o
);

   logic [IDX_W-1:0] ptr_q;

   // Combinational search from the pointer for the first pending request.
   always_comb begin
      int idx;
      // NOTE: every output gets a default before the search loop so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      grant_oh_o  = '0;
      grant_idx_o = '0;
      valid_o     = 1'b0;
      idx         = 0;
      for (int off = 0; off < NUM_CH; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!valid_o && req_i[IDX_W'(idx)]) begin
            valid_o                   = 1'b1;
            grant_idx_o               = IDX_W'(idx);
            grant_oh_o[IDX_W'(idx)]   = 1'b1;
         end
      end
   end

   // Pointer register: next search starts one past the last accepted grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: sequential state is always updated with non-blocking
         // assignments so every register samples pre-edge values.
         ptr_q <= '0;
      end else if (accept_i && valid_o) begin
         if (grant_idx_o == IDX_W'(NUM_CH - 1)) ptr_q <= '0;
         else                                   ptr_q <= grant_idx_o + IDX_W'(1);
      end
   end

endmodule

// File: rtl/user_event_gen.sv
// Multi-channel event source for the fakernet user-data port. Latches
// per-channel triggers, arbitrates round-robin, writes a framed event
// (two header words plus payload) into the event buffer and commits it.
module user_event_gen
   import user_event_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int MAX_WORDS = 1024,
   parameter int OFF_W     = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [NUM_CH-1:0] trig,
   input  logic [OFF_W-1:0]  len_cfg,
   input  logic [1:0]        mode,
   output logic [31:0]       ev_word,
   output logic [OFF_W-1:0]  ev_offset,
   output logic              ev_write,
   output logic [OFF_W:0]    ev_commit_len,
   output logic              ev_commit,
   input  logic              ev_free,
   input  logic              ev_reset,
   output logic [31:0]       ev_count,
   output logic [15:0]       drop_count
);

   localparam int             IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   // Two words of every event are header, so the payload is capped at
   // MAX_WORDS-2 to keep the whole event inside the buffer.
   localparam logic [OFF_W-1:0] MAX_N = OFF_W'(MAX_WORDS - 2);

   state_e              state_q;
   logic [NUM_CH-1:0]   pending_q, pending_d;
   logic [15:0]         drop_q;
   logic [IDX_W-1:0]    ch_q;
   logic [OFF_W-1:0]    n_q;
   logic [OFF_W-1:0]    k_q;
   logic [31:0]         lfsr_q;
   logic [31:0]         word_q;
   logic [OFF_W-1:0]    off_q;
   logic                write_q;
   logic                commit_q;
   logic [OFF_W:0]      commit_len_q;
   logic [31:0]         count_q;

   logic [NUM_CH-1:0]   grant_oh;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_valid;
   logic                accept;
   logic                drop_hit;
   logic [OFF_W-1:0]    n_clamp;
   logic [31:0]         hdr0_word;
   logic [31:0]         pay_word;

   assign accept = (state_q == ST_WAIT_FREE) && ev_free && !ev_reset && grant_valid;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .clk         (clk),
      .rstn        (rstn),
      .req_i       (pending_q),
      .accept_i    (accept),
      .grant_oh_o  (grant_oh),
      .grant_idx_o (grant_idx),
      .valid_o     (grant_valid)
   );

   // Next pending vector: new triggers set, an accepted grant clears,
   // and a producer abort wipes everything.
   always_comb begin
      pending_d = (pending_q & ~(accept ? grant_oh : '0)) | (trig & {NUM_CH{enable}});
      if (ev_reset) pending_d = '0;
      drop_hit = |(trig & pending_q);
   end

   // Pending flags and the saturating lost-trigger counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending_q <= '0;
         drop_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (drop_hit && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
   end

   // Header word 0 and the current payload word, built from the grant
   // (header) and from the event/word state (payload).
   always_comb begin
      n_clamp   = (len_cfg > MAX_N) ? MAX_N : len_cfg;
      hdr0_word = {HDR_MAGIC, 4'(grant_idx), 4'h0, 16'(n_clamp)};
      unique case (mode_e'(mode))
         MODE_INCR:  pay_word = {count_q[15:0], 16'(k_q)};
         MODE_FIXED: pay_word = {FIXED_PREFIX, 16'(k_q)};
         MODE_LFSR:  pay_word = lfsr_q;
         MODE_ZERO:  pay_word = '0;
         default:    pay_word = '0;
      endcase
   end

   // Event FSM. Output registers are loaded on the edge that enters a state,
   // so the state name always matches what is currently on the bus.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         n_q          <= '0;
         k_q          <= '0;
         lfsr_q       <= LFSR_SEED;
         word_q       <= '0;
         off_q        <= '0;
         write_q      <= 1'b0;
         commit_q     <= 1'b0;
         commit_len_q <= '0;
         count_q      <= '0;
      end else begin
         write_q  <= 1'b0;
         commit_q <= 1'b0;
         if (ev_reset) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (|pending_q) state_q <= ST_WAIT_FREE;
               end
               ST_WAIT_FREE: begin
                  if (!grant_valid) begin
                     state_q <= ST_IDLE;
                  end else if (ev_free) begin
                     ch_q    <= grant_idx;
                     n_q     <= n_clamp;
                     word_q  <= hdr0_word;
                     off_q   <= '0;
                     write_q <= 1'b1;
                     state_q <= ST_HDR0;
                  end
               end
               ST_HDR0: begin
                  word_q  <= count_q;
                  off_q   <= OFF_W'(1);
                  write_q <= 1'b1;
                  k_q     <= '0;
                  state_q <= ST_HDR1;
               end
               ST_HDR1, ST_PAYLOAD: begin
                  // k_q is the index of the next payload word to emit.
                  if (k_q == n_q) begin
                     commit_q     <= 1'b1;
                     commit_len_q <= {1'b0, n_q} + (OFF_W + 1)'(2);
                     count_q      <= count_q + 32'd1;
                     state_q      <= ST_COMMIT;
                  end else begin
                     word_q  <= pay_word;
                     off_q   <= k_q + OFF_W'(2);
                     write_q <= 1'b1;
                     k_q     <= k_q + OFF_W'(1);
                     lfsr_q  <= lfsr_next(lfsr_q);
                     state_q <= ST_PAYLOAD;
                  end
               end
               ST_COMMIT: begin
                  state_q <= ST_GAP;
               end
               ST_GAP: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ev_word       = word_q;
   assign ev_offset     = off_q;
   assign ev_write      = write_q;
   assign ev_commit     = commit_q;
   assign ev_commit_len = commit_len_q;
   assign ev_count      = count_q;
   assign drop_count    = drop_q;

endmodule

// File: tb/tb_user_event_gen.sv
// Self-checking bench for user_event_gen: a transaction-level model predicts
// every written word and commit; directed scenarios pin the model with literals.
module tb_user_event_gen;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic [3:0]  trig;
   logic [9:0]  len_cfg;
   logic [1:0]  mode;
   logic [31:0] ev_word;
   logic [9:0]  ev_offset;
   logic        ev_write;
   logic [10:0] ev_commit_len;
   logic        ev_commit;
   logic        ev_free;
   logic        ev_reset;
   logic [31:0] ev_count;
   logic [15:0] drop_count;

   always #4 clk = ~clk;

   user_event_gen #(
      .NUM_CH    (4),
      .MAX_WORDS (1024),
      .OFF_W     (10)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .enable        (enable),
      .trig          (trig),
      .len_cfg       (len_cfg),
      .mode          (mode),
      .ev_word       (ev_word),
      .ev_offset     (ev_offset),
      .ev_write      (ev_write),
      .ev_commit_len (ev_commit_len),
      .ev_commit     (ev_commit),
      .ev_free       (ev_free),
      .ev_reset      (ev_reset),
      .ev_count      (ev_count),
      .drop_count    (drop_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      int ch;
      int n;
      int md;
   } desc_t;

   desc_t       exp_q[$];
   desc_t       cur;
   bit          m_active  = 0;
   int          next_off  = 0;
   logic [31:0] m_count   = 0;
   logic [31:0] m_lfsr    = 32'hFFFF_FFFF;
   int          n_commits = 0;
   int          n_writes  = 0;
   logic [31:0] last_hdr0 = 0;
   logic [31:0] last_pay  = 0;
   int          last_off  = 0;
   int          last_len  = 0;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return (s << 1) | {31'd0, fb};
   endfunction

   function automatic logic [31:0] model_word(input int off);
      int k;
      if (off == 0) return 32'hEB00_0000 + 32'(cur.ch) * 32'h0010_0000 + 32'(cur.n);
      if (off == 1) return m_count;
      k = off - 2;
      case (cur.md)
         0:       return (m_count % 32'h1_0000) * 32'h1_0000 + 32'(k);
         1:       return 32'hA5A5_0000 + 32'(k);
         2:       return m_lfsr;
         default: return 32'h0;
      endcase
   endfunction

   // Compare process: every write and commit is checked against the model.
   always @(negedge clk) begin
      if (rstn) begin
         if (ev_write) begin
            n_writes++;
            if (ev_offset == 10'd0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_event", 1, 0);
                  m_active = 0;
               end else begin
                  cur      = exp_q.pop_front();
                  m_active = 1;
                  next_off = 0;
               end
            end
            if (m_active) begin
               check("offset", 64'(ev_offset), 64'(next_off));
               check("word", 64'(ev_word), 64'(model_word(next_off)));
               if (next_off == 0) last_hdr0 = ev_word;
               if (next_off >= 2) begin
                  last_pay = ev_word;
                  m_lfsr   = lfsr_step(m_lfsr);
               end
               last_off = int'(ev_offset);
               next_off++;
            end else if (ev_offset != 10'd0) begin
               check("stray_write", 1, 0);
            end
         end
         if (ev_commit) begin
            check("commit_with_write", 64'(ev_write), 0);
            if (!m_active) begin
               check("unexpected_commit", 1, 0);
            end else begin
               check("commit_len", 64'(ev_commit_len), 64'(cur.n + 2));
               check("words_before_commit", 64'(next_off), 64'(cur.n + 2));
               last_len = int'(ev_commit_len);
               m_count  = m_count + 32'd1;
               n_commits++;
               m_active = 0;
            end
         end
         check("ev_count", 64'(ev_count), 64'(m_count));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int c = 1);
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fire(input logic [3:0] m);
      trig = m;
      step();
      trig = '0;
   endtask

   task automatic expect_ev(input int ch, input int len, input int md);
      desc_t d;
      d.ch = ch;
      d.n  = (len > 1022) ? 1022 : len;
      d.md = md;
      exp_q.push_back(d);
   endtask

   task automatic wait_commits(input int target, input int budget, input string name);
      int c = 0;
      while (n_commits < target && c < budget) begin
         step();
         c++;
      end
      check(name, 64'(n_commits), 64'(target));
   endtask

   task automatic wait_off(input int o, input string name);
      int c = 0;
      while (!(ev_write && int'(ev_offset) == o) && c < 100) begin
         step();
         c++;
      end
      check(name, 64'(ev_write && int'(ev_offset) == o), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int base_w;
      int base_c;
      rstn     = 1'b0;
      enable   = 1'b1;
      trig     = '0;
      len_cfg  = '0;
      mode     = 2'd0;
      ev_free  = 1'b1;
      ev_reset = 1'b0;

      // Reset state
      #3;
      check("rst_word", 64'(ev_word), 0);
      check("rst_offset", 64'(ev_offset), 0);
      check("rst_write", 64'(ev_write), 0);
      check("rst_commit", 64'(ev_commit), 0);
      check("rst_commit_len", 64'(ev_commit_len), 0);
      check("rst_count", 64'(ev_count), 0);
      check("rst_drop", 64'(drop_count), 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step(2);

      // All four channels at once, LFSR payload, one word each: order 0..3
      len_cfg = 10'd1;
      mode    = 2'd2;
      for (int c = 0; c < 4; c++) expect_ev(c, 1, 2);
      fire(4'b1111);
      cnt = 1;
      while (!ev_write && cnt < 20) begin
         step();
         cnt++;
      end
      check("trig_to_write_latency", 64'(cnt), 3);
      wait_commits(4, 200, "all4_done");
      check("all4_last_lfsr", 64'(last_pay), 64'h0000_0000_FFFF_FFFB);
      check("all4_last_hdr", 64'(last_hdr0), 64'h0000_0000_EB30_0001);
      check("all4_drop", 64'(drop_count), 0);
      check("all4_count", 64'(ev_count), 4);
      step(3);

      // ch2, 4 incrementing words
      len_cfg = 10'd4;
      mode    = 2'd0;
      expect_ev(2, 4, 0);
      fire(4'b0100);
      wait_commits(5, 100, "ch2_done");
      check("ch2_hdr0", 64'(last_hdr0), 64'h0000_0000_EB20_0004);
      check("ch2_len", 64'(last_len), 6);
      check("ch2_last_off", 64'(last_off), 5);
      check("ch2_last_pay", 64'(last_pay), 64'h0000_0000_0004_0003);
      check("ch2_count", 64'(ev_count), 5);
      step(3);

      // ch1 triggered twice while the buffer is busy
      ev_free = 1'b0;
      len_cfg = 10'd2;
      mode    = 2'd1;
      expect_ev(1, 2, 1);
      fire(4'b0010);
      fire(4'b0010);
      step(3);
      check("drop_one", 64'(drop_count), 1);
      check("no_write_while_busy", 64'(n_writes), 64'(4 * 3 + 6));
      ev_free = 1'b1;
      wait_commits(6, 100, "drop_event_done");
      check("drop_last_pay", 64'(last_pay), 64'h0000_0000_A5A5_0001);
      base_w = n_writes;
      step(20);
      check("single_ch1_event", 64'(n_writes), 64'(base_w));

      // Triggers ignored while disabled
      enable = 1'b0;
      fire(4'b0001);
      step(10);
      check("disabled_no_event", 64'(n_writes), 64'(base_w));
      enable = 1'b1;

      // Zero-length payload
      len_cfg = 10'd0;
      mode    = 2'd3;
      expect_ev(0, 0, 3);
      fire(4'b0001);
      wait_commits(7, 100, "len0_done");
      check("len0_len", 64'(last_len), 2);
      check("len0_last_off", 64'(last_off), 1);
      step(3);

      // Clamped maximum length
      len_cfg = 10'd1023;
      expect_ev(1, 1023, 3);
      fire(4'b0010);
      wait_commits(8, 1200, "max_done");
      check("max_len", 64'(last_len), 1024);
      check("max_last_off", 64'(last_off), 1023);
      check("max_count", 64'(ev_count), 8);
      step(3);

      // Producer abort at payload word 3, with ch3 pending meanwhile
      len_cfg = 10'd8;
      mode    = 2'd2;
      expect_ev(0, 8, 2);
      fire(4'b0001);
      wait_off(3, "abort_reach_w1");
      fire(4'b1000);
      wait_off(5, "abort_reach_w3");
      base_c   = n_commits;
      ev_reset = 1'b1;
      step();
      ev_reset = 1'b0;
      m_active = 0;
      check("abort_write_low", 64'(ev_write), 0);
      base_w = n_writes;
      step(20);
      check("abort_no_commit", 64'(n_commits), 64'(base_c));
      check("abort_pending_cleared", 64'(n_writes), 64'(base_w));
      check("abort_count_kept", 64'(ev_count), 8);
      check("abort_drop_kept", 64'(drop_count), 1);

      // Next event continues count and LFSR
      len_cfg = 10'd2;
      expect_ev(1, 2, 2);
      fire(4'b0010);
      wait_commits(9, 100, "post_abort_done");
      check("post_abort_count", 64'(ev_count), 9);
      step(3);

      // Asynchronous reset mid-event
      len_cfg = 10'd6;
      mode    = 2'd0;
      expect_ev(0, 6, 0);
      fire(4'b0001);
      wait_off(3, "rst_reach_w1");
      #1;
      rstn = 1'b0;
      exp_q.delete();
      m_active = 0;
      m_count  = 0;
      m_lfsr   = 32'hFFFF_FFFF;
      #1;
      check("arst_word", 64'(ev_word), 0);
      check("arst_offset", 64'(ev_offset), 0);
      check("arst_write", 64'(ev_write), 0);
      check("arst_commit", 64'(ev_commit), 0);
      check("arst_commit_len", 64'(ev_commit_len), 0);
      check("arst_count", 64'(ev_count), 0);
      check("arst_drop", 64'(drop_count), 0);
      step(2);
      rstn = 1'b1;
      step(2);

      // First event after reset: ch2, 4 words, count restarts
      len_cfg = 10'd4;
      expect_ev(2, 4, 0);
      fire(4'b0100);
      wait_commits(10, 100, "after_rst_done");
      check("after_rst_hdr0", 64'(last_hdr0), 64'h0000_0000_EB20_0004);
      check("after_rst_len", 64'(last_len), 6);
      check("after_rst_last_pay", 64'(last_pay), 64'h0000_0000_0000_0003);
      check("after_rst_count", 64'(ev_count), 1);
      step(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
